// File: rtl/spi_loader_pkg.sv
// Shared opcodes, mode encodings, FSM state codes and status-bit layout for the SPI matrix loader.
// Latency: n/a (constants only).
// Backpressure: n/a.
package spi_loader_pkg;
    localparam logic [7:0] OP_LOAD_A = 8'h01;
    localparam logic [7:0] OP_LOAD_B = 8'h02;
    localparam logic [7:0] OP_FINISH = 8'h03;
    localparam logic [7:0] OP_DIMS   = 8'h04;
    localparam logic [7:0] OP_CLR    = 8'h05;

    localparam logic [1:0] MODE_IDLE = 2'b00;
    localparam logic [1:0] MODE_A    = 2'b01;
    localparam logic [1:0] MODE_B    = 2'b10;
    localparam logic [1:0] MODE_FIN  = 2'b11;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_OPCODE = 3'd1;
    localparam logic [2:0] ST_LOAD_A = 3'd2;
    localparam logic [2:0] ST_LOAD_B = 3'd3;
    localparam logic [2:0] ST_DIMS   = 3'd4;
    localparam logic [2:0] ST_SKIP   = 3'd5;

    // Bit positions inside the MISO status byte; bits 2:0 read as zero.
    localparam int STAT_OVF   = 7;
    localparam int STAT_OP    = 6;
    localparam int STAT_DIM   = 5;
    localparam int STAT_FRAME = 4;
    localparam int STAT_DV    = 3;
endpackage

// File: rtl/spi_slave_sync_shift.sv
// SPI mode-0 slave front end: 2-FF synchronisers, sclk/cs_n edge detect, MSB-first byte shifter, MISO status shifter.
// Latency: byte_vld/byte_dat are combinational in the clk cycle where the synchronised 8th sclk rise is seen.
// Backpressure: none; the host paces bytes, sclk must stay at or below clk/8.
module spi_slave_sync_shift (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    input  logic [7:0] status,
    output logic       cs_fall,
    output logic       cs_rise,
    output logic       byte_vld,
    output logic [7:0] byte_dat,
    output logic       spi_miso
);
    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_prev;
    logic       cs_prev;
    logic       sclk_rise;
    logic       sclk_fall;
    logic [2:0] bit_cnt;
    logic [6:0] shift;
    logic [7:0] miso_sr;
    logic       miso_en;

    // cs_n synchroniser resets to the deselected level so reset alone never looks like a frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[0], spi_sclk};
            cs_sync   <= {cs_sync[0], spi_cs_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            sclk_prev <= sclk_sync[1];
            cs_prev   <= cs_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sync[1] & sclk_prev;
    assign cs_fall   = ~cs_sync[1] & cs_prev;
    assign cs_rise   = cs_sync[1] & ~cs_prev;
    assign byte_vld  = sclk_rise & ~cs_sync[1] & (bit_cnt == 3'd7);
    assign byte_dat  = {shift, mosi_sync[1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= 3'd0;
            shift   <= 7'd0;
        end else if (cs_sync[1]) begin
            bit_cnt <= 3'd0;
        end else if (sclk_rise) begin
            shift   <= {shift[5:0], mosi_sync[1]};
            bit_cnt <= bit_cnt + 3'd1;
        end
    end

    // Status is only driven during the opcode byte; the first bit is presented before the first rise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            miso_sr <= 8'd0;
            miso_en <= 1'b0;
        end else if (cs_fall) begin
            miso_sr <= status;
            miso_en <= 1'b1;
        end else if (cs_sync[1] || byte_vld) begin
            miso_en <= 1'b0;
        end else if (sclk_fall && miso_en) begin
            miso_sr <= {miso_sr[6:0], 1'b0};
        end
    end

    assign spi_miso = miso_en & miso_sr[7];
endmodule

// File: rtl/spi_matrix_loader.sv
// SPI slave that decodes per-frame opcodes and feeds 32-bit words, mode strobes and M/K/N dims to the SIPO stage.
// Latency: mode/serial_out update 1 clk after the synchronised sclk rise that completes a word or opcode.
// Backpressure: none; words past the programmed M*K or K*N limit are dropped and flagged as overflow.
module spi_matrix_loader #(
    parameter int MAX_M = 100,
    parameter int MAX_K = 100,
    parameter int MAX_N = 100,
    parameter int DIM_W = 8,
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_sclk,
    input  logic             spi_cs_n,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic [31:0]      serial_out,
    output logic [1:0]       mode,
    output logic [DIM_W-1:0] M_out,
    output logic [DIM_W-1:0] K_out,
    output logic [DIM_W-1:0] N_out,
    output logic             err
);
    import spi_loader_pkg::*;

    localparam int PROD_W = 2 * DIM_W;

    logic              cs_fall;
    logic              cs_rise;
    logic              byte_vld;
    logic [7:0]        byte_dat;
    logic [7:0]        status;
    logic [2:0]        state;
    logic [1:0]        byte_idx;
    logic [23:0]       word_sr;
    logic [DIM_W-1:0]  m_buf;
    logic [DIM_W-1:0]  k_buf;
    logic [DIM_W-1:0]  dim_n;
    logic [CNT_W-1:0]  cnt_a;
    logic [CNT_W-1:0]  cnt_b;
    logic [CNT_W-1:0]  cnt_cur;
    logic [PROD_W-1:0] lim_a;
    logic [PROD_W-1:0] lim_b;
    logic              load_b;
    logic              room;
    logic              dims_ok;
    logic              ovf_err;
    logic              op_err;
    logic              dim_err;
    logic              frame_err;
    logic              dims_valid;

    always_comb begin
        status             = 8'd0;
        status[STAT_OVF]   = ovf_err;
        status[STAT_OP]    = op_err;
        status[STAT_DIM]   = dim_err;
        status[STAT_FRAME] = frame_err;
        status[STAT_DV]    = dims_valid;
    end

    spi_slave_sync_shift u_spi (
        .clk      (clk),
        .rst      (rst),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .status   (status),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .byte_vld (byte_vld),
        .byte_dat (byte_dat),
        .spi_miso (spi_miso)
    );

    // Unprogrammed dims give a zero limit, so every word overflows.
    assign lim_a   = PROD_W'(M_out) * PROD_W'(K_out);
    assign lim_b   = PROD_W'(K_out) * PROD_W'(N_out);
    assign load_b  = (state == ST_LOAD_B);
    assign cnt_cur = load_b ? cnt_b : cnt_a;
    assign room    = PROD_W'(cnt_cur) < (load_b ? lim_b : lim_a);
    assign dim_n   = byte_dat[DIM_W-1:0];
    assign dims_ok = (m_buf != '0) && (m_buf <= DIM_W'(MAX_M)) &&
                     (k_buf != '0) && (k_buf <= DIM_W'(MAX_K)) &&
                     (dim_n != '0) && (dim_n <= DIM_W'(MAX_N));
    assign err     = ovf_err | op_err | dim_err | frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            byte_idx   <= 2'd0;
            word_sr    <= 24'd0;
            m_buf      <= '0;
            k_buf      <= '0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            ovf_err    <= 1'b0;
            op_err     <= 1'b0;
            dim_err    <= 1'b0;
            frame_err  <= 1'b0;
            dims_valid <= 1'b0;
            serial_out <= 32'd0;
            mode       <= MODE_IDLE;
            M_out      <= '0;
            K_out      <= '0;
            N_out      <= '0;
        end else begin
            mode <= MODE_IDLE;
            if (cs_rise) begin
                if ((state == ST_LOAD_A || state == ST_LOAD_B) && byte_idx != 2'd0)
                    frame_err <= 1'b1;
                state    <= ST_IDLE;
                byte_idx <= 2'd0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        byte_idx <= 2'd0;
                        if (cs_fall)
                            state <= ST_OPCODE;
                    end
                    ST_OPCODE: if (byte_vld) begin
                        byte_idx <= 2'd0;
                        case (byte_dat)
                            OP_LOAD_A: state <= ST_LOAD_A;
                            OP_LOAD_B: state <= ST_LOAD_B;
                            OP_DIMS:   state <= ST_DIMS;
                            OP_FINISH: begin
                                mode  <= MODE_FIN;
                                state <= ST_SKIP;
                            end
                            OP_CLR: begin
                                ovf_err   <= 1'b0;
                                op_err    <= 1'b0;
                                dim_err   <= 1'b0;
                                frame_err <= 1'b0;
                                state     <= ST_SKIP;
                            end
                            default: begin
                                op_err <= 1'b1;
                                state  <= ST_SKIP;
                            end
                        endcase
                    end
                    ST_LOAD_A, ST_LOAD_B: if (byte_vld) begin
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            if (room) begin
                                serial_out <= {word_sr, byte_dat};
                                mode       <= load_b ? MODE_B : MODE_A;
                                if (load_b) cnt_b <= cnt_b + 1'b1;
                                else        cnt_a <= cnt_a + 1'b1;
                            end else begin
                                ovf_err <= 1'b1;
                            end
                        end else begin
                            word_sr <= {word_sr[15:0], byte_dat};
                        end
                    end
                    ST_DIMS: if (byte_vld && byte_idx != 2'd3) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: m_buf <= dim_n;
                            2'd1: k_buf <= dim_n;
                            default: begin
                                if (dims_ok) begin
                                    M_out      <= m_buf;
                                    K_out      <= k_buf;
                                    N_out      <= dim_n;
                                    dims_valid <= 1'b1;
                                    cnt_a      <= '0;
                                    cnt_b      <= '0;
                                end else begin
                                    dim_err <= 1'b1;
                                end
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_matrix_loader.sv
// Directed + randomised SPI frames against a frame-level reference model of the loader.
module tb_spi_matrix_loader;
    localparam int HALF = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_cs_n = 1'b1;
    logic        spi_mosi = 1'b0;
    logic        spi_miso;
    logic [31:0] serial_out;
    logic [1:0]  mode;
    logic [7:0]  M_out, K_out, N_out;
    logic        err;

    always #5 clk = ~clk;

    spi_matrix_loader dut (
        .clk        (clk),
        .rst        (rst),
        .spi_sclk   (spi_sclk),
        .spi_cs_n   (spi_cs_n),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .serial_out (serial_out),
        .mode       (mode),
        .M_out      (M_out),
        .K_out      (K_out),
        .N_out      (N_out),
        .err        (err)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: every non-idle mode sample, plus a count of strobes lasting more than 1 clk.
    logic [33:0] obs_q[$];
    logic [1:0]  prev_mode = 2'b00;
    int          wide = 0;
    always @(negedge clk) begin
        if (mode != 2'b00) begin
            obs_q.push_back({mode, serial_out});
            if (prev_mode != 2'b00) wide++;
        end
        prev_mode = mode;
    end

    // Reference model state, updated once per frame from the whole byte list.
    int          m_m = 0, m_k = 0, m_n = 0, cnt_a = 0, cnt_b = 0;
    bit          dv = 0, e_ovf = 0, e_op = 0, e_dim = 0, e_frame = 0;
    logic [31:0] last_word = 0;
    logic [33:0] exp_q[$];
    logic [7:0]  tx_q[$];

    task automatic model_frame(output logic [7:0] st);
        int n, lim, cnt;
        logic [31:0] w;
        logic [7:0] op;
        st = {e_ovf, e_op, e_dim, e_frame, dv, 3'b000};
        op = tx_q[0];
        n  = tx_q.size() - 1;
        case (op)
            8'h01, 8'h02: begin
                lim = (op == 8'h01) ? m_m * m_k : m_k * m_n;
                cnt = (op == 8'h01) ? cnt_a : cnt_b;
                for (int i = 0; i < n / 4; i++) begin
                    w = {tx_q[1+4*i], tx_q[2+4*i], tx_q[3+4*i], tx_q[4+4*i]};
                    if (cnt < lim) begin
                        cnt++;
                        last_word = w;
                        exp_q.push_back({(op == 8'h01) ? 2'b01 : 2'b10, w});
                    end else begin
                        e_ovf = 1;
                    end
                end
                if (op == 8'h01) cnt_a = cnt; else cnt_b = cnt;
                if (n % 4 != 0) e_frame = 1;
            end
            8'h03: exp_q.push_back({2'b11, last_word});
            8'h04: if (n >= 3) begin
                if (tx_q[1] >= 1 && tx_q[1] <= 100 && tx_q[2] >= 1 && tx_q[2] <= 100 &&
                    tx_q[3] >= 1 && tx_q[3] <= 100) begin
                    m_m = tx_q[1]; m_k = tx_q[2]; m_n = tx_q[3];
                    dv = 1; cnt_a = 0; cnt_b = 0;
                end else begin
                    e_dim = 1;
                end
            end
            8'h05: begin e_ovf = 0; e_op = 0; e_dim = 0; e_frame = 0; end
            default: e_op = 1;
        endcase
    endtask

    task automatic send_byte(input logic [7:0] b, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = b[i];
            #(HALF);
            rx[i] = spi_miso;
            spi_sclk = 1'b1;
            #(HALF);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic new_frame(input logic [7:0] op);
        tx_q.delete();
        tx_q.push_back(op);
    endtask

    task automatic add_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) tx_q.push_back(w[8*i +: 8]);
    endtask

    task automatic run_frame(input string tag);
        logic [7:0]  st_exp, st_got, rx;
        logic [33:0] e, o;
        model_frame(st_exp);
        st_got = 8'h00;
        @(negedge clk);
        #2;
        spi_cs_n = 1'b0;
        for (int i = 0; i < tx_q.size(); i++) begin
            send_byte(tx_q[i], rx);
            if (i == 0) st_got = rx;
        end
        #(HALF);
        spi_cs_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        check({tag, " status"}, 32'(st_got), 32'(st_exp));
        check({tag, " strobes"}, 32'(obs_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            check({tag, " mode"}, 32'(o[33:32]), 32'(e[33:32]));
            check({tag, " word"}, o[31:0], e[31:0]);
        end
        obs_q.delete();
        check({tag, " wide"}, 32'(wide), 32'd0);
        check({tag, " M"}, 32'(M_out), 32'(m_m));
        check({tag, " K"}, 32'(K_out), 32'(m_k));
        check({tag, " N"}, 32'(N_out), 32'(m_n));
        check({tag, " err"}, 32'(err), 32'(e_ovf | e_op | e_dim | e_frame));
    endtask

    initial begin
        logic [7:0] rx;
        int mm, kk, nn;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst mode", 32'(mode), 32'd0);
        check("rst serial_out", serial_out, 32'd0);
        check("rst M", 32'(M_out), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst miso", 32'(spi_miso), 32'd0);
        rst = 1'b0;
        repeat (5) @(posedge clk);

        new_frame(8'h04); tx_q.push_back(8'd2); tx_q.push_back(8'd3); tx_q.push_back(8'd2);
        run_frame("dims 2/3/2");
        new_frame(8'h01); for (int i = 1; i <= 6; i++) add_word(32'(i));
        run_frame("load A x6");
        new_frame(8'h02); repeat (7) add_word($urandom());
        run_frame("load B x7");
        new_frame(8'h05);
        run_frame("clr after ovf");
        new_frame(8'h04); tx_q.push_back(8'd2); tx_q.push_back(8'd3); tx_q.push_back(8'd2);
        run_frame("dims again");
        new_frame(8'h01); add_word($urandom()); tx_q.push_back(8'h5A);
        run_frame("partial A");
        new_frame(8'h03);
        run_frame("finish");
        new_frame(8'h7F);
        run_frame("bad op");
        new_frame(8'h05);
        run_frame("clr");
        new_frame(8'h04); tx_q.push_back(8'd0); tx_q.push_back(8'd5); tx_q.push_back(8'd5);
        run_frame("dims zero");
        new_frame(8'h04); tx_q.push_back(8'd101); tx_q.push_back(8'd1); tx_q.push_back(8'd1);
        run_frame("dims 101");
        new_frame(8'h04); tx_q.push_back(8'd4); tx_q.push_back(8'd4);
        run_frame("dims partial");

        for (int r = 0; r < 5; r++) begin
            mm = $urandom_range(1, 3); kk = $urandom_range(1, 3); nn = $urandom_range(1, 3);
            new_frame(8'h04); tx_q.push_back(8'(mm)); tx_q.push_back(8'(kk)); tx_q.push_back(8'(nn));
            run_frame("rnd dims");
            new_frame(8'h01);
            repeat ($urandom_range(0, mm * kk + 1)) add_word($urandom());
            if ($urandom_range(0, 3) == 0) tx_q.push_back(8'($urandom()));
            run_frame("rnd A");
            new_frame(8'h02);
            repeat ($urandom_range(0, kk * nn + 1)) add_word($urandom());
            run_frame("rnd B");
            new_frame(($urandom_range(0, 1) == 0) ? 8'h03 : 8'h05);
            run_frame("rnd ctl");
        end

        // Reset in the middle of a LOAD_A word.
        @(negedge clk);
        #2;
        spi_cs_n = 1'b0;
        send_byte(8'h01, rx);
        send_byte(8'hAA, rx);
        send_byte(8'hBB, rx);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst mode", 32'(mode), 32'd0);
        check("midrst serial_out", serial_out, 32'd0);
        check("midrst M", 32'(M_out), 32'd0);
        check("midrst K", 32'(K_out), 32'd0);
        check("midrst N", 32'(N_out), 32'd0);
        check("midrst err", 32'(err), 32'd0);
        check("midrst miso", 32'(spi_miso), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #(HALF);
        spi_cs_n = 1'b1;
        repeat (20) @(posedge clk);
        m_m = 0; m_k = 0; m_n = 0; cnt_a = 0; cnt_b = 0;
        dv = 0; e_ovf = 0; e_op = 0; e_dim = 0; e_frame = 0; last_word = 0;
        exp_q.delete();
        check("midrst strobes", 32'(obs_q.size()), 32'd0);
        obs_q.delete();
        new_frame(8'h04); tx_q.push_back(8'd3); tx_q.push_back(8'd1); tx_q.push_back(8'd2);
        run_frame("post rst dims");
        new_frame(8'h01); repeat (3) add_word($urandom());
        run_frame("post rst A");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
